// File: rtl/uart_tx_param.sv
// uart_tx_param
// -----------------------------------------------------------------------------
// Parameterised UART transmitter. Bytes are accepted into a holding store via a
// valid/ready handshake and serialised as: start bit (0), DATA_BITS data bits
// LSB first, optional parity bit, STOP_BITS stop bits (1). Each bit lasts
// CLKS_PER_BIT clock cycles. Back-to-back frames are sent with no idle bit
// when the holding store already has the next byte.
//
// Configuration macro: UART_TX_FIFO_EN
//   undefined : holding store is a single register (FIFO_DEPTH ignored)
//   defined   : holding store is a FIFO_DEPTH-entry FIFO
//
// Parameters
//   DATA_BITS    payload bits per frame (5..9)
//   CLKS_PER_BIT clk cycles per serial bit (2..65535)
//   PARITY_MODE  0 = none, 1 = even, 2 = odd
//   STOP_BITS    1 or 2
//   FIFO_DEPTH   FIFO entries, power of two 2..16 (FIFO build only)
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset; aborts any frame
//   data_bus   in   byte to transmit
//   data_valid in   data_bus holds a byte
//   data_ready out  store can accept data_bus on this edge
//   serial_out out  registered serial line, idle high
//   busy       out  high while a frame is on the line
//   tx_done    out  one-cycle pulse after the last stop bit
//   fsm_state  out  current FSM state encoding (debug)
//
// Handshake: a byte transfers on every rising edge where data_valid and
// data_ready are both high, and on no other edge. data_ready depends only on
// registered state, never combinationally on data_valid.
// -----------------------------------------------------------------------------
module uart_tx_param #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_bus,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 tx_done,
  output logic [2:0]           fsm_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic       PAR_ODD   = (PARITY_MODE == 2);

  // Reject illegal configurations at elaboration.
  if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 ||
      PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_tx_param: illegal parameter set");
  end

  state_t               state;
  logic [BAUD_W-1:0]    baud;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 ready_en;

  logic                 store_empty;
  logic                 store_full;
  logic [DATA_BITS-1:0] store_head;
  logic                 push;
  logic                 load;
  logic                 baud_last;

  assign baud_last  = (baud == BAUD_LAST);
  assign push       = data_valid & data_ready;
  // ready_en holds data_ready low through reset and lifts it on the first edge after.
  assign data_ready = ready_en & ~store_full;
  assign fsm_state  = state;

  // The shift register is loaded from the store when idle, or straight out of
  // the final stop bit so consecutive frames have no gap.
  assign load = ~store_empty &
                ((state == IDLE) ||
                 (state == STOP && baud_last && bit_cnt == STOP_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_en <= 1'b0;
    else     ready_en <= 1'b1;
  end

`ifdef UART_TX_FIFO_EN
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count;

  assign store_empty = (count == '0);
  assign store_full  = (count == FULL_COUNT);
  assign store_head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_bus;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
`else
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_data;

  assign store_empty = ~hold_full;
  assign store_full  = hold_full;
  assign store_head  = hold_data;

  // push requires hold_full low and load requires it high, so they never
  // coincide on one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      if (load) hold_full <= 1'b0;
      if (push) begin
        hold_full <= 1'b1;
        hold_data <= data_bus;
      end
    end
  end
`endif

  // Transmit FSM. serial_out is assigned the value of the bit being entered,
  // so the line is driven straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud       <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      serial_out <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (load) begin
        if (state == STOP) tx_done <= 1'b1;
        state      <= START;
        baud       <= '0;
        bit_cnt    <= '0;
        shift      <= store_head;
        par_bit    <= (^store_head) ^ PAR_ODD;
        serial_out <= 1'b0;
        busy       <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            serial_out <= 1'b1;
            busy       <= 1'b0;
          end
          START: begin
            if (baud_last) begin
              state      <= DATA;
              baud       <= '0;
              bit_cnt    <= '0;
              serial_out <= shift[0];
            end else begin
              baud <= baud + 1'b1;
            end
          end
          DATA: begin
            if (baud_last) begin
              baud <= '0;
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                if (PARITY_MODE != 0) begin
                  state      <= PARITY;
                  serial_out <= par_bit;
                end else begin
                  state      <= STOP;
                  serial_out <= 1'b1;
                end
              end else begin
                // shift[1] is the next data bit before the shift lands.
                bit_cnt    <= bit_cnt + 1'b1;
                shift      <= shift >> 1;
                serial_out <= shift[1];
              end
            end else begin
              baud <= baud + 1'b1;
            end
          end
          PARITY: begin
            if (baud_last) begin
              state      <= STOP;
              baud       <= '0;
              bit_cnt    <= '0;
              serial_out <= 1'b1;
            end else begin
              baud <= baud + 1'b1;
            end
          end
          STOP: begin
            if (baud_last) begin
              baud <= '0;
              if (bit_cnt == STOP_LAST) begin
                tx_done    <= 1'b1;
                bit_cnt    <= '0;
                state      <= IDLE;
                busy       <= 1'b0;
                serial_out <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              baud <= baud + 1'b1;
            end
          end
          default: begin
            state      <= IDLE;
            serial_out <= 1'b1;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Testbench for uart_tx_param: five instances cover no/even/odd parity, two
// stop bits and a 5-bit payload, all at 4 clocks per bit.
module tb_uart_tx_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] din  [5];
  logic       vin  [5];
  logic       rdy  [5];
  logic       so   [5];
  logic       bsy  [5];
  logic       done [5];
  logic [2:0] st   [5];

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .data_bus(din[0]), .data_valid(vin[0]), .data_ready(rdy[0]),
    .serial_out(so[0]), .busy(bsy[0]), .tx_done(done[0]), .fsm_state(st[0]));
  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .data_bus(din[1]), .data_valid(vin[1]), .data_ready(rdy[1]),
    .serial_out(so[1]), .busy(bsy[1]), .tx_done(done[1]), .fsm_state(st[1]));
  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .data_bus(din[2]), .data_valid(vin[2]), .data_ready(rdy[2]),
    .serial_out(so[2]), .busy(bsy[2]), .tx_done(done[2]), .fsm_state(st[2]));
  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rst(rst), .data_bus(din[3]), .data_valid(vin[3]), .data_ready(rdy[3]),
    .serial_out(so[3]), .busy(bsy[3]), .tx_done(done[3]), .fsm_state(st[3]));
  uart_tx_param #(.DATA_BITS(5), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .data_bus(din[4][4:0]), .data_valid(vin[4]), .data_ready(rdy[4]),
    .serial_out(so[4]), .busy(bsy[4]), .tx_done(done[4]), .fsm_state(st[4]));

  // ---------------- scoreboard state ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [0:0] exp_q [$];
  logic cap_so [$];
  logic cap_busy [$];
  logic cap_done [$];

  typedef struct {
    int          inst;
    logic [7:0]  d;
    int          nbits;
    logic [15:0] frame;   // line bits, first-transmitted bit leftmost
    string       name;
  } vec_t;
  vec_t vecs [$];

  logic [7:0] fb [6];
  int w [6];
  int t1, t2, cnt_b, cnt_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Presents b on instance i and returns once it has been accepted.
  task automatic push(input int i, input logic [7:0] b, output int waits);
    waits = 0;
    din[i] = b;
    vin[i] = 1'b1;
    while (!rdy[i] && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    check($sformatf("accept_u%0d_%02h", i, b), rdy[i], 1);
    @(posedge clk);
    #1 vin[i] = 1'b0;
  endtask

  task automatic capture(input int i, input int n);
    cap_so.delete();
    cap_busy.delete();
    cap_done.delete();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cap_so.push_back(so[i]);
      cap_busy.push_back(bsy[i]);
      cap_done.push_back(done[i]);
    end
  endtask

  task automatic exp_idle(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(1'b1);
  endtask

  task automatic exp_frame(input logic [15:0] f, input int nbits);
    for (int k = 0; k < nbits; k++)
      for (int c = 0; c < 4; c++) exp_q.push_back(f[nbits-1-k]);
  endtask

  // Reference framing for the 8N1 instance.
  task automatic exp_byte8(input logic [7:0] d);
    for (int c = 0; c < 4; c++) exp_q.push_back(1'b0);
    for (int b = 0; b < 8; b++)
      for (int c = 0; c < 4; c++) exp_q.push_back(d[b]);
    for (int c = 0; c < 4; c++) exp_q.push_back(1'b1);
  endtask

  task automatic score(input string tag);
    check({tag, "_len"}, cap_so.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < cap_so.size(); k++)
      check($sformatf("%s_line[%0d]", tag, k), cap_so[k], exp_q[k]);
    exp_q.delete();
  endtask

  task automatic count_caps(output int nb, output int nd);
    nb = 0;
    nd = 0;
    foreach (cap_busy[k]) begin
      if (cap_busy[k]) nb++;
      if (cap_done[k]) nd++;
    end
  endtask

  // Sends one byte from idle and checks the whole frame, busy span and tx_done.
  task automatic run_vec(input vec_t v);
    int nb, nd, len;
    len = v.nbits * 4;
    @(negedge clk);
    check({v.name, "_ready"}, rdy[v.inst], 1);
    din[v.inst] = v.d;
    vin[v.inst] = 1'b1;
    @(posedge clk);
    #1 vin[v.inst] = 1'b0;
    capture(v.inst, len + 6);
    exp_q.push_back(1'b1);       // line still idle one sample after acceptance
    exp_frame(v.frame, v.nbits);
    exp_idle(5);
    score(v.name);
    count_caps(nb, nd);
    check({v.name, "_busy_cycles"}, nb, len);
    check({v.name, "_done_pulses"}, nd, 1);
    check({v.name, "_done_pos"}, cap_done[len+1], 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din[i] = 8'h00;
      vin[i] = 1'b0;
    end

    vecs.push_back('{0, 8'hA7, 10, 16'b0_11100101_1,   "u0_a7"});
    vecs.push_back('{0, 8'h00, 10, 16'b0_00000000_1,   "u0_00"});
    vecs.push_back('{0, 8'hFF, 10, 16'b0_11111111_1,   "u0_ff"});
    vecs.push_back('{1, 8'hA7, 11, 16'b0_11100101_1_1, "even_a7"});
    vecs.push_back('{2, 8'hA7, 11, 16'b0_11100101_0_1, "odd_a7"});
    vecs.push_back('{1, 8'h03, 11, 16'b0_11000000_0_1, "even_03"});
    vecs.push_back('{2, 8'h03, 11, 16'b0_11000000_1_1, "odd_03"});
    vecs.push_back('{3, 8'h55, 11, 16'b0_10101010_11,  "stop2_55"});
    vecs.push_back('{4, 8'h1F, 7,  16'b0_11111_1,      "d5_1f"});
    vecs.push_back('{4, 8'hEA, 7,  16'b0_01010_1,      "d5_ea"});

    // Reset values while rst is held.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rst_so_u%0d", i),    so[i],   1);
      check($sformatf("rst_busy_u%0d", i),  bsy[i],  0);
      check($sformatf("rst_done_u%0d", i),  done[i], 0);
      check($sformatf("rst_ready_u%0d", i), rdy[i],  0);
      check($sformatf("rst_state_u%0d", i), st[i],   0);
    end
    rst = 1'b0;
    #1 check("ready_before_first_edge", rdy[0], 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) check($sformatf("ready_after_rst_u%0d", i), rdy[i], 1);

    // Table-driven single frames.
    foreach (vecs[v]) run_vec(vecs[v]);

    // Back-to-back frames with two stop bits: no idle gap between them.
    @(negedge clk);
    fork
      begin
        push(3, 8'h55, t1);
        push(3, 8'h0F, t2);
      end
      capture(3, 100);
    join
    exp_q.push_back(1'b1);
    exp_frame(16'b0_10101010_11, 11);
    exp_frame(16'b0_11110000_11, 11);
    exp_idle(100 - 89);
    score("b2b");
    count_caps(cnt_b, cnt_d);
    check("b2b_busy_cycles", cnt_b, 88);
    check("b2b_done_pulses", cnt_d, 2);
    check("b2b_done_first", cap_done[45], 1);
    check("b2b_done_second", cap_done[89], 1);

`ifdef UART_TX_FIFO_EN
    // Six bytes offered continuously into a 4-deep FIFO.
    fb = '{8'h11, 8'h22, 8'hC3, 8'h5A, 8'h80, 8'h01};
    @(negedge clk);
    fork
      begin
        for (int j = 0; j < 6; j++) push(0, fb[j], w[j]);
      end
      capture(0, 260);
    join
    for (int j = 0; j < 5; j++) check($sformatf("fifo_wait_%0d", j), w[j], 0);
    check("fifo_full_stalls_sixth", (w[5] > 0), 1);
    exp_q.push_back(1'b1);
    for (int j = 0; j < 6; j++) exp_byte8(fb[j]);
    exp_idle(260 - 241);
    score("fifo");
    count_caps(cnt_b, cnt_d);
    check("fifo_busy_cycles", cnt_b, 240);
    check("fifo_done_pulses", cnt_d, 6);
`else
    // Holding register: second byte waits for the drain; data offered while
    // not ready is ignored.
    @(negedge clk);
    fork
      begin
        push(0, 8'hA7, t1);
        push(0, 8'h12, t2);
        @(negedge clk);
        din[0] = 8'hEE;
        vin[0] = 1'b1;
        repeat (20) @(negedge clk);
        check("hold_full_not_ready", rdy[0], 0);
        vin[0] = 1'b0;
      end
      capture(0, 100);
    join
    check("hold_first_wait", t1, 0);
    check("hold_second_wait", t2, 2);
    exp_q.push_back(1'b1);
    exp_byte8(8'hA7);
    exp_byte8(8'h12);
    exp_idle(100 - 81);
    score("hold");
    count_caps(cnt_b, cnt_d);
    check("hold_busy_cycles", cnt_b, 80);
    check("hold_done_pulses", cnt_d, 2);
`endif

    // Reset in the middle of a frame, then a clean frame afterwards.
    @(negedge clk);
    din[0] = 8'hA7;
    vin[0] = 1'b1;
    @(posedge clk);
    #1 vin[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_busy_before", bsy[0], 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_so", so[0], 1);
    check("midrst_busy", bsy[0], 0);
    check("midrst_state", st[0], 0);
    check("midrst_ready", rdy[0], 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_ready_held_low", rdy[0], 0);
    @(negedge clk);
    check("midrst_ready_up", rdy[0], 1);
    check("midrst_idle_so", so[0], 1);
    check("midrst_idle_busy", bsy[0], 0);
    check("midrst_no_done", done[0], 0);
    run_vec('{0, 8'h3C, 10, 16'b0_00111100_1, "after_rst_3c"});

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
